// File: rtl/elevator_pkg.sv
// ============================================================================
//  Module   : elevator_pkg
//  Purpose  : Shared button counts, bit indices and per-button debounce
//             state encoding for the elevator button front end.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package elevator_pkg;

    localparam int NUM_HALL_BUTTONS = 4;
    localparam int NUM_CAR_BUTTONS  = 3;

    // Hall button bit positions
    localparam int HALL_F3_DN = 0;
    localparam int HALL_F2_UP = 1;
    localparam int HALL_F2_DN = 2;
    localparam int HALL_F1_UP = 3;

    // Car button bit positions
    localparam int CAR_F3 = 0;
    localparam int CAR_F2 = 1;
    localparam int CAR_F1 = 2;

    // Per-button debounce state
    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

endpackage

`default_nettype wire

// File: rtl/elevator_button_conditioner_debounce.sv
// ============================================================================
//  Module   : button_debounce
//  Purpose  : Single-bit synchroniser, debouncer and stuck detector. Emits a
//             one-cycle pulse per accepted press and a sticky stuck flag.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debounce
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STUCK_CYCLES    = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse,
    output logic stuck
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW = $clog2(STUCK_CYCLES + 1);

    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] STUCK_MAX = SW'(STUCK_CYCLES);

    logic           sync1_q, sync1_d;
    logic           sync_q, sync_d;
    btn_state_e     state_q, state_d;
    logic [DW-1:0]  cnt_q, cnt_d;
    logic [SW-1:0]  stuck_cnt_q, stuck_cnt_d;
    logic           stuck_q, stuck_d;
    logic           pulse_q, pulse_d;
    logic [SW-1:0]  stuck_cnt_inc;

    // Register all state; async reset returns the bit to RELEASED and drops any pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync_q      <= 1'b0;
            state_q     <= RELEASED;
            cnt_q       <= '0;
            stuck_cnt_q <= '0;
            stuck_q     <= 1'b0;
            pulse_q     <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stuck_cnt_q <= stuck_cnt_d;
            stuck_q     <= stuck_d;
            pulse_q     <= pulse_d;
        end
    end

    // Next-state: synchroniser shift, debounce FSM and saturating stuck timer
    always_comb begin
        sync1_d       = raw;
        sync_d        = sync1_q;
        state_d       = state_q;
        cnt_d         = cnt_q;
        stuck_cnt_d   = stuck_cnt_q;
        stuck_d       = stuck_q;
        pulse_d       = 1'b0;
        stuck_cnt_inc = (stuck_cnt_q == STUCK_MAX) ? stuck_cnt_q : stuck_cnt_q + SW'(1);

        case (state_q)
            RELEASED: begin
                if (sync_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync_q) begin
                    state_d = RELEASED;
                end else if (cnt_q == DB_LAST) begin
                    // Accepted press: pulse once and start the stuck timer from zero
                    state_d     = PRESSED;
                    pulse_d     = 1'b1;
                    stuck_cnt_d = '0;
                    stuck_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            PRESSED: begin
                stuck_cnt_d = stuck_cnt_inc;
                stuck_d     = stuck_q | (stuck_cnt_inc == STUCK_MAX);
                if (!sync_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (sync_q) begin
                    // Release bounce: back to held, no second pulse
                    state_d     = PRESSED;
                    stuck_cnt_d = stuck_cnt_inc;
                    stuck_d     = stuck_q | (stuck_cnt_inc == STUCK_MAX);
                end else if (cnt_q == DB_LAST) begin
                    state_d     = RELEASED;
                    stuck_cnt_d = '0;
                    stuck_d     = 1'b0;
                end else begin
                    cnt_d       = cnt_q + DW'(1);
                    stuck_cnt_d = stuck_cnt_inc;
                    stuck_d     = stuck_q | (stuck_cnt_inc == STUCK_MAX);
                end
            end
            default: begin
                state_d = RELEASED;
            end
        endcase
    end

    assign pulse = pulse_q;
    assign stuck = stuck_q;

endmodule

`default_nettype wire

// File: rtl/elevator_button_conditioner.sv
// ============================================================================
//  Module   : elevator_button_conditioner
//  Purpose  : Front end for the elevator controller. Debounces every hall and
//             car button into single-cycle press pulses and flags stuck ones.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module elevator_button_conditioner
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STUCK_CYCLES    = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_HALL_BUTTONS-1:0] floor_button_raw,
    input  logic [NUM_CAR_BUTTONS-1:0]  elevator_button_raw,
    output logic [NUM_HALL_BUTTONS-1:0] floor_button_pressed,
    output logic [NUM_CAR_BUTTONS-1:0]  elevator_floor_button_pressed,
    output logic [NUM_HALL_BUTTONS-1:0] floor_button_stuck,
    output logic [NUM_CAR_BUTTONS-1:0]  elevator_button_stuck,
    output logic                        any_stuck
);

    logic any_stuck_q, any_stuck_d;

    generate
        for (genvar i = 0; i < NUM_HALL_BUTTONS; i++) begin : g_hall
            button_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .STUCK_CYCLES    (STUCK_CYCLES)
            ) u_debounce (
                .clk   (clk),
                .rst   (rst),
                .raw   (floor_button_raw[i]),
                .pulse (floor_button_pressed[i]),
                .stuck (floor_button_stuck[i])
            );
        end

        for (genvar j = 0; j < NUM_CAR_BUTTONS; j++) begin : g_car
            button_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .STUCK_CYCLES    (STUCK_CYCLES)
            ) u_debounce (
                .clk   (clk),
                .rst   (rst),
                .raw   (elevator_button_raw[j]),
                .pulse (elevator_floor_button_pressed[j]),
                .stuck (elevator_button_stuck[j])
            );
        end
    endgenerate

    // Summary stuck flag, one cycle behind the per-bit flags
    always_comb begin
        any_stuck_d = |{floor_button_stuck, elevator_button_stuck};
    end

    // Register the summary flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            any_stuck_q <= 1'b0;
        end else begin
            any_stuck_q <= any_stuck_d;
        end
    end

    assign any_stuck = any_stuck_q;

endmodule

`default_nettype wire

// File: tb/tb_elevator_button_conditioner.sv
// ============================================================================
//  Module   : tb_elevator_button_conditioner
//  Purpose  : Directed, table-driven bench for elevator_button_conditioner
//             with DEBOUNCE_CYCLES=4, STUCK_CYCLES=64.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_elevator_button_conditioner;
    import elevator_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] floor_raw;
    logic [2:0] car_raw;
    logic [3:0] fp;
    logic [2:0] cp;
    logic [3:0] fs;
    logic [2:0] cs;
    logic       any_st;

    int n_checks = 0;
    int n_fail   = 0;

    // Observed outputs packed as {fp, cp, fs, cs, any}
    logic [14:0] obs;
    assign obs = {fp, cp, fs, cs, any_st};

    typedef struct {
        string       tag;
        logic [3:0]  fl;
        logic [2:0]  car;
        logic [14:0] exp;
    } vec_t;

    vec_t vecs[$];

    elevator_button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .STUCK_CYCLES    (64)
    ) dut (
        .clk                           (clk),
        .rst                           (rst),
        .floor_button_raw              (floor_raw),
        .elevator_button_raw           (car_raw),
        .floor_button_pressed          (fp),
        .elevator_floor_button_pressed (cp),
        .floor_button_stuck            (fs),
        .elevator_button_stuck         (cs),
        .any_stuck                     (any_st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] pack(input logic [3:0] efp, input logic [2:0] ecp,
                                         input logic [3:0] efs, input logic [2:0] ecs,
                                         input logic eany);
        return {efp, ecp, efs, ecs, eany};
    endfunction

    task automatic check(input string name, input logic [14:0] got, input logic [14:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got fp=%b cp=%b fs=%b cs=%b any=%b, expected fp=%b cp=%b fs=%b cs=%b any=%b",
                     name, $time, got[14:11], got[10:8], got[7:4], got[3:1], got[0],
                     exp[14:11], exp[10:8], exp[7:4], exp[3:1], exp[0]);
        end
    endtask

    // Drive inputs just after an edge; they are sampled at the next edge and
    // outputs are read 1 time unit after that edge.
    task automatic step(input logic [3:0] f, input logic [2:0] c);
        floor_raw = f;
        car_raw   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string tag, input logic [3:0] f, input logic [2:0] c,
                       input logic [3:0] efp, input logic [2:0] ecp);
        vec_t v;
        v.tag = tag;
        v.fl  = f;
        v.car = c;
        v.exp = pack(efp, ecp, 4'b0, 3'b0, 1'b0);
        vecs.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:17] pat4;
        logic [3:0]  f_all;
        logic [2:0]  c_all;

        floor_raw = '0;
        car_raw   = '0;
        rst       = 1'b0;

        // ---- Reset with every button held, then release reset ----
        f_all = 4'hF;
        c_all = 3'h7;
        #2 rst = 1'b1;
        #1 check("reset_async", obs, 15'd0);
        for (int i = 0; i < 3; i++) begin
            step(f_all, c_all);
            check("reset_held", obs, 15'd0);
        end
        rst = 1'b0;
        // First post-reset edge samples the held buttons; pulse 6 edges later
        for (int p = 1; p <= 24; p++) begin
            step((p <= 10) ? f_all : 4'h0, (p <= 10) ? c_all : 3'h0);
            check("post_reset_press", obs,
                  pack((p == 7) ? f_all : 4'h0, (p == 7) ? c_all : 3'h0, 4'h0, 3'h0, 1'b0));
        end

        // ---- Build the vector table ----
        // Hall F3-dn held 8 edges: pulse after edge 6 only
        for (int r = 0; r < 16; r++)
            add("single_press", (r < 8) ? 4'b0001 << HALL_F3_DN : 4'b0, 3'b0,
                (r == 6) ? 4'b0001 << HALL_F3_DN : 4'b0, 3'b0);
        // Hall F1-up pressed for 1..5 edges: only the 5-edge press qualifies
        for (int w = 1; w <= 5; w++)
            for (int r = 0; r < w + 10; r++)
                add((w == 5) ? "min_width_5" : "short_press",
                    (r < w) ? 4'b1000 : 4'b0, 3'b0,
                    (w == 5 && r == 6) ? 4'b1000 : 4'b0, 3'b0);
        // Car F2 with press bounce then release bounce
        pat4 = 18'b10111111_0100000_000;
        for (int r = 0; r < 18; r++)
            add("bounce", 4'b0, pat4[r] ? 3'b010 : 3'b000,
                4'b0, (r == 8) ? 3'b010 : 3'b000);
        // Four buttons rising together
        for (int r = 0; r < 16; r++)
            add("simultaneous", (r < 8) ? 4'b0110 : 4'b0, (r < 8) ? 3'b011 : 3'b0,
                (r == 6) ? 4'b0110 : 4'b0, (r == 6) ? 3'b011 : 3'b0);

        // ---- Apply the table ----
        foreach (vecs[i]) begin
            step(vecs[i].fl, vecs[i].car);
            check(vecs[i].tag, obs, vecs[i].exp);
        end

        // ---- Stuck: car F1 held for 80 edges ----
        for (int t = 0; t < 96; t++) begin
            step(4'b0, (t < 80) ? 3'b100 : 3'b000);
            check("stuck", obs,
                  pack(4'b0, (t == 6) ? 3'b100 : 3'b000, 4'b0,
                       (t >= 70 && t < 86) ? 3'b100 : 3'b000,
                       (t >= 71 && t < 87)));
        end

        // ---- Reset in the middle of PRESS_WAIT, button kept held ----
        for (int s = 0; s < 4; s++) begin
            step(4'b0010, 3'b0);
            check("mid_wait_pre_rst", obs, 15'd0);
        end
        rst = 1'b1;
        #1 check("mid_wait_rst", obs, 15'd0);
        for (int s = 0; s < 2; s++) begin
            step(4'b0010, 3'b0);
            check("mid_wait_in_rst", obs, 15'd0);
        end
        rst = 1'b0;
        for (int p = 1; p <= 20; p++) begin
            step((p <= 10) ? 4'b0010 : 4'b0, 3'b0);
            check("mid_wait_requalify", obs,
                  pack((p == 7) ? 4'b0010 : 4'b0, 3'b0, 4'b0, 3'b0, 1'b0));
        end

        // ---- Reset while a pulse is on the output drops it at once ----
        for (int s = 0; s < 7; s++) begin
            step(4'b0001, 3'b0);
            check("drop_pulse_pre", obs,
                  pack((s == 6) ? 4'b0001 : 4'b0, 3'b0, 4'b0, 3'b0, 1'b0));
        end
        rst = 1'b1;
        #1 check("drop_pulse_rst", obs, 15'd0);
        step(4'b0, 3'b0);
        rst = 1'b0;
        for (int s = 0; s < 8; s++) begin
            step(4'b0, 3'b0);
            check("drop_pulse_after", obs, 15'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
